// File: rtl/barrel_shifter_pkg.sv
// Shared encodings and sizing helpers for the barrel shifter and ALU decode.
package barrel_shifter_pkg;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    // One extra bit above log2(width) so a shift of exactly width is expressible.
    function automatic int shiftAmountWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/barrel_shifter_stage.sv
// One 2:1 mux layer of the shift network: shifts left by 2**STAGE when enabled.
module barrel_shifter_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGE = 0
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned DIST = 1 << STAGE;

    assign data_o = enable_i ? (data_i << DIST) : data_i;

endmodule

// File: rtl/barrel_shifter.sv
// Registered logical barrel shifter; right shifts reuse the left network via bit reversal.
module barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [WIDTH-1:0]                     value,
    input  logic [shiftAmountWidth(WIDTH)-1:0]   shift_amount,
    input  logic                                 direction,
    output logic [WIDTH-1:0]                     result
);

    localparam int STAGES = $clog2(WIDTH);
    localparam int SAW    = shiftAmountWidth(WIDTH);

    logic [WIDTH-1:0] valueRev;
    logic [WIDTH-1:0] netOutRev;
    logic [WIDTH-1:0] stageData [STAGES+1];
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_reverse
        assign valueRev[i]  = value[WIDTH-1-i];
        assign netOutRev[i] = stageData[STAGES][WIDTH-1-i];
    end

    assign stageData[0] = (direction == SHIFT_RIGHT) ? valueRev : value;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        barrel_shifter_stage #(
            .WIDTH (WIDTH),
            .STAGE (g)
        ) u_stage (
            .data_i   (stageData[g]),
            .enable_i (shift_amount[g]),
            .data_o   (stageData[g+1])
        );
    end

    // MSB of the amount means a shift of WIDTH or more: everything falls off, no wrap.
    always_comb begin
        result_d = '0;
        if (!shift_amount[SAW-1]) begin
            result_d = (direction == SHIFT_RIGHT) ? netOutRev : stageData[STAGES];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed vector table, reset/timing sequences and random checks at WIDTH 32, 8 and 64.
module tb_barrel_shifter;
    import barrel_shifter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] value, result;
    logic [5:0]  shiftAmount;
    logic        direction;

    logic [7:0]  value8, result8;
    logic [3:0]  shiftAmount8;
    logic        dir8;

    logic [63:0] value64, result64;
    logic [6:0]  shiftAmount64;
    logic        dir64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] value;
        logic [5:0]  amount;
        logic        dir;
        logic [31:0] expected;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    barrel_shifter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .value(value), .shift_amount(shiftAmount),
        .direction(direction), .result(result)
    );

    barrel_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .value(value8), .shift_amount(shiftAmount8),
        .direction(dir8), .result(result8)
    );

    barrel_shifter #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .value(value64), .shift_amount(shiftAmount64),
        .direction(dir64), .result(result64)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] v, input logic [5:0] a, input logic d);
        value       = v;
        shiftAmount = a;
        direction   = d;
    endtask

    // Reference: plain shift operators on a w-bit operand, zero once amount >= w.
    function automatic logic [63:0] refShift(input logic [63:0] v, input int amt, input logic d, input int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (amt >= w) return 64'd0;
        r = (d == SHIFT_RIGHT) ? ((v & mask) >> amt) : ((v & mask) << amt);
        return r & mask;
    endfunction

    initial begin
        logic [63:0] exp32, exp8, exp64;

        vecs[0]  = '{"left10",     32'hFFFF_FFFF, 6'd10, SHIFT_LEFT,  32'hFFFF_FC00};
        vecs[1]  = '{"right10",    32'hFFFF_FFFF, 6'd10, SHIFT_RIGHT, 32'h003F_FFFF};
        vecs[2]  = '{"zeroLeft",   32'hA5A5_1234, 6'd0,  SHIFT_LEFT,  32'hA5A5_1234};
        vecs[3]  = '{"zeroRight",  32'hA5A5_1234, 6'd0,  SHIFT_RIGHT, 32'hA5A5_1234};
        vecs[4]  = '{"left31",     32'h0000_0001, 6'd31, SHIFT_LEFT,  32'h8000_0000};
        vecs[5]  = '{"right31",    32'h8000_0000, 6'd31, SHIFT_RIGHT, 32'h0000_0001};
        vecs[6]  = '{"left32",     32'hFFFF_FFFF, 6'd32, SHIFT_LEFT,  32'h0000_0000};
        vecs[7]  = '{"right32",    32'hFFFF_FFFF, 6'd32, SHIFT_RIGHT, 32'h0000_0000};
        vecs[8]  = '{"left63",     32'hFFFF_FFFF, 6'd63, SHIFT_LEFT,  32'h0000_0000};
        vecs[9]  = '{"right63",    32'hFFFF_FFFF, 6'd63, SHIFT_RIGHT, 32'h0000_0000};
        vecs[10] = '{"left4",      32'h1234_5678, 6'd4,  SHIFT_LEFT,  32'h2345_6780};
        vecs[11] = '{"right4",     32'h1234_5678, 6'd4,  SHIFT_RIGHT, 32'h0123_4567};
        vecs[12] = '{"left16",     32'h0000_FFFF, 6'd16, SHIFT_LEFT,  32'hFFFF_0000};
        vecs[13] = '{"right16",    32'hFFFF_0000, 6'd16, SHIFT_RIGHT, 32'h0000_FFFF};
        vecs[14] = '{"msbOutLeft", 32'h8000_0000, 6'd1,  SHIFT_LEFT,  32'h0000_0000};
        vecs[15] = '{"lsbOutRight",32'h0000_0001, 6'd1,  SHIFT_RIGHT, 32'h0000_0000};

        reset = 1'b1;
        applyStimulus(32'h1234_5678, 6'd3, SHIFT_LEFT);
        value8 = 8'hFF; shiftAmount8 = 4'd0; dir8 = SHIFT_LEFT;
        value64 = '1;   shiftAmount64 = 7'd0; dir64 = SHIFT_LEFT;

        repeat (2) @(negedge clk);
        checkOutput("resetInit32", {32'd0, result}, 64'd0);
        checkOutput("resetInit8", {56'd0, result8}, 64'd0);
        checkOutput("resetInit64", result64, 64'd0);

        // Reset wins over a live operation, then the first edge without reset is reflected.
        applyStimulus(32'hFFFF_FFFF, 6'd0, SHIFT_LEFT);
        @(negedge clk);
        checkOutput("resetHold", {32'd0, result}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetRelease", {32'd0, result}, 64'h0000_0000_FFFF_FFFF);

        // Back-to-back: each vector is checked on the edge after it was applied.
        for (int i = 0; i <= NVEC; i++) begin
            if (i > 0) checkOutput(vecs[i-1].name, {32'd0, result}, {32'd0, vecs[i-1].expected});
            if (i < NVEC) applyStimulus(vecs[i].value, vecs[i].amount, vecs[i].dir);
            @(negedge clk);
        end
        checkOutput("lastVecHeld", {32'd0, result}, {32'd0, vecs[NVEC-1].expected});

        // Input changes between edges must not reach the output early.
        applyStimulus(32'h0000_00F0, 6'd4, SHIFT_RIGHT);
        @(posedge clk);
        #1 checkOutput("midAfterEdge", {32'd0, result}, 64'h0000_0000_0000_000F);
        #2 applyStimulus(32'h0000_00F0, 6'd8, SHIFT_LEFT);
        @(negedge clk);
        checkOutput("midHeld", {32'd0, result}, 64'h0000_0000_0000_000F);
        @(posedge clk);
        #1 checkOutput("midNextEdge", {32'd0, result}, 64'h0000_0000_0000_F000);

        // Mid-stream reset pulse.
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(32'hDEAD_BEEF, 6'd0, SHIFT_LEFT);
        @(negedge clk);
        checkOutput("midReset", {32'd0, result}, 64'd0);
        reset = 1'b0;
        applyStimulus(32'hDEAD_BEEF, 6'd8, SHIFT_RIGHT);
        @(negedge clk);
        checkOutput("midResetRelease", {32'd0, result}, 64'h0000_0000_00DE_ADBE);

        // Random operations on all three widths, one-cycle-delayed reference.
        exp32 = '0; exp8 = '0; exp64 = '0;
        for (int i = 0; i <= 3000; i++) begin
            if (i > 0) begin
                checkOutput("rand32", {32'd0, result}, exp32);
                checkOutput("rand8", {56'd0, result8}, exp8);
                checkOutput("rand64", result64, exp64);
            end
            applyStimulus($urandom, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            value8        = 8'($urandom_range(0, 255));
            shiftAmount8  = 4'($urandom_range(0, 15));
            dir8          = 1'($urandom_range(0, 1));
            value64       = {$urandom, $urandom};
            shiftAmount64 = 7'($urandom_range(0, 127));
            dir64         = 1'($urandom_range(0, 1));
            exp32 = refShift({32'd0, value}, int'(shiftAmount), direction, 32);
            exp8  = refShift({56'd0, value8}, int'(shiftAmount8), dir8, 8);
            exp64 = refShift(value64, int'(shiftAmount64), dir64, 64);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
